wb_queue: RTL and testbench



---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_fifo.sv | 61 ++++++
 rtl/wb_queue.sv | 187 ++++++++++++++++++
 tb/tb_wb_queue.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and default sizes for the writeback queue.
// Imported by wb_fifo and wb_queue.
package wb_pkg;

   localparam int WB_DW    = 32;
   localparam int WB_AW    = 5;
   localparam int WB_DEPTH = 4;

   typedef struct packed {
      logic [WB_AW-1:0] addr;
      logic [WB_DW-1:0] data;
   } wb_entry_t;

   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_LD  = 1'b1
   } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: 2-push/1-pop circular buffer; push0 is always the older entry.
// With WB_FWD_EN it also exposes its entries ordered oldest-first.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   parameter type entry_t = wb_entry_t,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic          ck,
   input  logic          rst_n,
   input  logic          push0,
   input  entry_t        entry0,
   input  logic          push1,
   input  entry_t        entry1,
   input  logic          pop,
   output entry_t        head,
   output logic [CW-1:0] count
`ifdef WB_FWD_EN
   ,
   output entry_t [DEPTH-1:0] ageEntry,
   output logic [DEPTH-1:0]   ageValid
`endif
);

   entry_t [DEPTH-1:0] mem;
   logic [PW-1:0] rdPtr;
   logic [PW-1:0] wrPtr;
   logic [PW-1:0] wrPtrNext;

   assign wrPtrNext = wrPtr + PW'(1);

   // Storage needs no reset: count alone decides what is live.
   always_ff @(posedge ck) begin
      if (push0) mem[wrPtr] <= entry0;
      if (push1) mem[wrPtrNext] <= entry1;
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (pop) rdPtr <= rdPtr + PW'(1);
         wrPtr <= wrPtr + PW'(push0) + PW'(push1);
         count <= count + CW'(push0) + CW'(push1) - CW'(pop);
      end
   end

   assign head = mem[rdPtr];

`ifdef WB_FWD_EN
   for (genvar k = 0; k < DEPTH; k++) begin : gAge
      assign ageEntry[k] = mem[rdPtr + PW'(k)];
      assign ageValid[k] = CW'(k) < count;
   end
`endif

endmodule

// File: rtl/wb_queue.sv
// wb_queue: two-source writeback queue feeding the register-file port.
// Define WB_FWD_EN to add the fwd_* lookup ports for decode.
module wb_queue
   import wb_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   parameter int DW = WB_DW,
   parameter int AW = WB_AW,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic          ck,
   input  logic          rst_n,
   input  logic          alu_valid,
   output logic          alu_ready,
   input  logic [AW-1:0] alu_addr,
   input  logic [DW-1:0] alu_data,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   output logic [CW-1:0] count,
   output logic          busy
`ifdef WB_FWD_EN
   ,
   input  logic [AW-1:0] fwd_addr1,
   input  logic [AW-1:0] fwd_addr2,
   output logic          fwd_hit1,
   output logic          fwd_hit2,
   output logic [DW-1:0] fwd_data1,
   output logic [DW-1:0] fwd_data2
`endif
);

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } entry_t;

   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_LEFT = CW'(DEPTH - 1);

   wb_src_e prio;
   entry_t aluEntry;
   entry_t ldEntry;
   entry_t firstEntry;
   entry_t secondEntry;
   entry_t head;
   logic prioValid;
   logic prioReady;
   logic otherReady;
   logic aluFire;
   logic ldFire;
   logic aluPush;
   logic ldPush;
   logic firstPush;
   logic secondPush;
   logic pop;
   logic bothValid;
   logic refused;
   logic dual;

   assign aluEntry = '{addr: alu_addr, data: alu_data};
   assign ldEntry = '{addr: ld_addr, data: ld_data};

   // The non-priority ready looks only at the other channel's valid.
   assign prioValid = (prio == WB_SRC_LD) ? ld_valid : alu_valid;
   assign prioReady = rst_n && (count != FULL);
   assign otherReady = rst_n && ((count < ONE_LEFT) ||
      ((count == ONE_LEFT) && !prioValid));

   assign alu_ready = (prio == WB_SRC_ALU) ? prioReady : otherReady;
   assign ld_ready = (prio == WB_SRC_LD) ? prioReady : otherReady;

   assign aluFire = alu_valid && alu_ready;
   assign ldFire = ld_valid && ld_ready;
   assign aluPush = aluFire && (alu_addr != '0);
   assign ldPush = ldFire && (ld_addr != '0);

   always_comb begin
      if (prio == WB_SRC_ALU) begin
         firstPush = aluPush;
         firstEntry = aluEntry;
         secondPush = ldPush;
         secondEntry = ldEntry;
      end else begin
         firstPush = ldPush;
         firstEntry = ldEntry;
         secondPush = aluPush;
         secondEntry = aluEntry;
      end
   end

   assign pop = count != '0;

`ifdef WB_FWD_EN
   entry_t [DEPTH-1:0] ageEntry;
   logic [DEPTH-1:0] ageValid;
`endif

   wb_fifo #(
      .DEPTH(DEPTH),
      .entry_t(entry_t)
   ) uFifo (
      .ck(ck),
      .rst_n(rst_n),
      .push0(firstPush || secondPush),
      .entry0(firstPush ? firstEntry : secondEntry),
      .push1(firstPush && secondPush),
      .entry1(secondEntry),
      .pop(pop),
      .head(head),
      .count(count)
`ifdef WB_FWD_EN
      ,
      .ageEntry(ageEntry),
      .ageValid(ageValid)
`endif
   );

   assign bothValid = alu_valid && ld_valid;
   assign dual = aluFire && ldFire;
   assign refused = !aluFire || !ldFire;

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         prio <= WB_SRC_ALU;
      end else if (bothValid && (refused || dual)) begin
         prio <= wb_src_e'(~prio);
      end
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         wr_en <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= pop;
         if (pop) begin
            wr_addr <= head.addr;
            wr_data <= head.data;
         end
      end
   end

   assign busy = (count != '0) || wr_en;

`ifdef WB_FWD_EN
   // Oldest first so the youngest match overrides.
   always_comb begin
      fwd_hit1 = 1'b0;
      fwd_data1 = '0;
      fwd_hit2 = 1'b0;
      fwd_data2 = '0;
      if (wr_en && (wr_addr == fwd_addr1)) begin
         fwd_hit1 = 1'b1;
         fwd_data1 = wr_data;
      end
      if (wr_en && (wr_addr == fwd_addr2)) begin
         fwd_hit2 = 1'b1;
         fwd_data2 = wr_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
         if (ageValid[k] && (ageEntry[k].addr == fwd_addr1)) begin
            fwd_hit1 = 1'b1;
            fwd_data1 = ageEntry[k].data;
         end
         if (ageValid[k] && (ageEntry[k].addr == fwd_addr2)) begin
            fwd_hit2 = 1'b1;
            fwd_data2 = ageEntry[k].data;
         end
      end
      if (!rst_n || (fwd_addr1 == '0)) begin
         fwd_hit1 = 1'b0;
         fwd_data1 = '0;
      end
      if (!rst_n || (fwd_addr2 == '0)) begin
         fwd_hit2 = 1'b0;
         fwd_data2 = '0;
      end
   end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed and random checks of wb_queue against a
// transaction-level queue model.
module tb_wb_queue;

   localparam int DEPTH = 4;

   logic        ck;
   logic        rst_n;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_addr;
   logic [31:0] alu_data;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_addr;
   logic [31:0] ld_data;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [2:0]  count;
   logic        busy;
`ifdef WB_FWD_EN
   logic [4:0]  fwd_addr1;
   logic [4:0]  fwd_addr2;
   logic        fwd_hit1;
   logic        fwd_hit2;
   logic [31:0] fwd_data1;
   logic [31:0] fwd_data2;
`endif

   wb_queue dut (
      .ck(ck),
      .rst_n(rst_n),
      .alu_valid(alu_valid),
      .alu_ready(alu_ready),
      .alu_addr(alu_addr),
      .alu_data(alu_data),
      .ld_valid(ld_valid),
      .ld_ready(ld_ready),
      .ld_addr(ld_addr),
      .ld_data(ld_data),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .count(count),
      .busy(busy)
`ifdef WB_FWD_EN
      ,
      .fwd_addr1(fwd_addr1),
      .fwd_addr2(fwd_addr2),
      .fwd_hit1(fwd_hit1),
      .fwd_hit2(fwd_hit2),
      .fwd_data1(fwd_data1),
      .fwd_data2(fwd_data2)
`endif
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   int          mPrio = 0;
   logic        expEn = 1'b0;
   logic [4:0]  expA = '0;
   logic [31:0] expD = '0;
   int          tests = 0;
   int          fails = 0;
   int          wrSeen = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pushIf(input logic t, input logic [4:0] a,
                         input logic [31:0] d);
      if (t && (a != 5'd0)) q.push_back('{a, d});
   endtask

`ifdef WB_FWD_EN
   task automatic fwdCheck(input string tag, input logic [4:0] a,
                           input logic h, input logic [31:0] d);
      logic eh;
      logic [31:0] ed;
      eh = 1'b0;
      ed = '0;
      if (a != 5'd0) begin
         if (expEn && (expA == a)) begin
            eh = 1'b1;
            ed = expD;
         end
         foreach (q[i]) begin
            if (q[i].a == a) begin
               eh = 1'b1;
               ed = q[i].d;
            end
         end
      end
      chk({tag, "_hit"}, h, eh);
      if (eh) chk({tag, "_data"}, d, ed);
   endtask
`endif

   task automatic checkOut();
      chk("wr_en", wr_en, expEn);
      chk("wr_addr", wr_addr, expA);
      chk("wr_data", wr_data, expD);
      chk("count", count, q.size());
      chk("busy", busy, (q.size() != 0) || expEn);
      if (wr_en === 1'b1) wrSeen++;
`ifdef WB_FWD_EN
      fwdCheck("fwd1", fwd_addr1, fwd_hit1, fwd_data1);
      fwdCheck("fwd2", fwd_addr2, fwd_hit2, fwd_data2);
`endif
   endtask

   // One clock: drive at negedge, check readies, model the edge, check.
   task automatic cyc(input logic av, input logic [4:0] aa,
                      input logic [31:0] ad, input logic lv,
                      input logic [4:0] la, input logic [31:0] ldd,
                      output logic aTook, output logic lTook);
      int freeSlots;
      logic aR;
      logic lR;
      logic pV;
      ent_t e;
      alu_valid = av;
      alu_addr = aa;
      alu_data = ad;
      ld_valid = lv;
      ld_addr = la;
      ld_data = ldd;
      #1;
      freeSlots = DEPTH - q.size();
      pV = (mPrio == 1) ? lv : av;
      if (freeSlots >= 2) begin
         aR = 1'b1;
         lR = 1'b1;
      end else if (freeSlots == 1) begin
         aR = (mPrio == 0) ? 1'b1 : !pV;
         lR = (mPrio == 1) ? 1'b1 : !pV;
      end else begin
         aR = 1'b0;
         lR = 1'b0;
      end
      chk("alu_ready", alu_ready, aR);
      chk("ld_ready", ld_ready, lR);
      aTook = av && aR;
      lTook = lv && lR;
      if (q.size() != 0) begin
         e = q.pop_front();
         expEn = 1'b1;
         expA = e.a;
         expD = e.d;
      end else begin
         expEn = 1'b0;
      end
      if (mPrio == 0) begin
         pushIf(aTook, aa, ad);
         pushIf(lTook, la, ldd);
      end else begin
         pushIf(lTook, la, ldd);
         pushIf(aTook, aa, ad);
      end
      if (av && lv) mPrio = 1 - mPrio;
      @(posedge ck);
      #1;
      checkOut();
      @(negedge ck);
   endtask

   task automatic idle(input int n);
      logic x;
      logic y;
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, x, y);
   endtask

   initial begin
      logic at;
      logic lt;
      int ai;
      int li;
      rst_n = 1'b0;
      alu_valid = 1'b1;
      alu_addr = 5'd1;
      alu_data = '0;
      ld_valid = 1'b1;
      ld_addr = 5'd2;
      ld_data = '0;
`ifdef WB_FWD_EN
      fwd_addr1 = 5'd7;
      fwd_addr2 = 5'd0;
`endif
      #3;
      chk("rst_alu_ready", alu_ready, 0);
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_count", count, 0);
      chk("rst_busy", busy, 0);
      repeat (2) @(negedge ck);
      rst_n = 1'b1;

      cyc(1, 5'd3, 32'hDEADBEEF, 0, 0, 0, at, lt);
      idle(1);
      chk("r3_wr_addr", wr_addr, 3);
      chk("r3_count", count, 0);
      idle(1);

      cyc(1, 5'd1, 32'h101, 1, 5'd9, 32'h109, at, lt);
      cyc(1, 5'd2, 32'h102, 1, 5'd10, 32'h10A, at, lt);
      cyc(1, 5'd3, 32'h103, 1, 5'd11, 32'h10B, at, lt);
      idle(5);

      cyc(1, 5'd0, 32'h1234, 1, 5'd5, 32'h55, at, lt);
      chk("r0_count", count, 1);
      idle(3);

      wrSeen = 0;
      ai = 1;
      li = 9;
      for (int n = 0; n < 30; n++) begin
         cyc(ai <= 8, 5'(ai), 32'hA000_0000 + ai,
             li <= 16, 5'(li), 32'hB000_0000 + li, at, lt);
         if (at) ai++;
         if (lt) li++;
      end
      chk("stream_writes", wrSeen, 16);

      cyc(1, 5'd7, 32'h11, 0, 0, 0, at, lt);
      cyc(0, 0, 0, 1, 5'd7, 32'h22, at, lt);
`ifdef WB_FWD_EN
      chk("fwd_r7_hit", fwd_hit1, 1);
      chk("fwd_r7_data", fwd_data1, 32'h22);
      chk("fwd_r0_hit", fwd_hit2, 0);
`endif
      idle(4);

      cyc(1, 5'd20, 32'h20, 1, 5'd21, 32'h21, at, lt);
      cyc(1, 5'd22, 32'h22, 1, 5'd23, 32'h23, at, lt);
      alu_valid = 1'b1;
      ld_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wr_en", wr_en, 0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_alu_ready", alu_ready, 0);
      chk("mid_rst_ld_ready", ld_ready, 0);
      chk("mid_rst_busy", busy, 0);
      q.delete();
      expEn = 1'b0;
      expA = '0;
      expD = '0;
      mPrio = 0;
      repeat (2) @(negedge ck);
      rst_n = 1'b1;
      idle(4);

      for (int n = 0; n < 400; n++) begin
`ifdef WB_FWD_EN
         fwd_addr1 = 5'($urandom_range(0, 7));
         fwd_addr2 = 5'($urandom_range(0, 7));
`endif
         cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             $urandom, 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), $urandom, at, lt);
      end
      idle(6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
